// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UartTX between two byte requesters.
// Each grant loads the UART, waits for its busy flag to rise and fall, then idles GAP cycles.
module uart_tx_arbiter #(
  parameter int unsigned GAP          = 0,
  parameter int unsigned BUSY_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [7:0]  data0,
  output logic        ack0,
  input  logic        req1,
  input  logic [7:0]  data1,
  output logic        ack1,
  output logic        tx_load,
  output logic [15:0] tx_in,
  input  logic [15:0] tx_out,
  output logic        busy,
  output logic [1:0]  grant,
  output logic        err
);

  localparam int unsigned TO_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(BUSY_TIMEOUT - 1);
  localparam logic [15:0]     GAP_LOAD = (GAP == 0) ? 16'd0 : 16'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      byte_q, byte_d;
  logic [1:0]      grant_q, grant_d;
  logic            prio1_q, prio1_d;
  logic            err_q, err_d;
  logic            tx_load_q, tx_load_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic            busy_q, busy_d;
  logic [15:0]     gap_q, gap_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            win1;

  wire uart_busy = tx_out[15];

  logic unused_tx_bits;
  assign unused_tx_bits = ^tx_out[14:0];

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    grant_d   = grant_q;
    prio1_d   = prio1_q;
    err_d     = err_q;
    tx_load_d = 1'b0;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    gap_d     = gap_q;
    to_d      = to_q;
    win1      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // The UART has no reset, so a frame started before our reset may still be running.
        if (!uart_busy && (req0 || req1)) begin
          win1      = req1 && (!req0 || prio1_q);
          byte_d    = win1 ? data1 : data0;
          grant_d   = win1 ? 2'b10 : 2'b01;
          tx_load_d = 1'b1;
          ack0_d    = !win1;
          ack1_d    = win1;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        prio1_d = grant_q[0];
        to_d    = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (uart_busy) begin
          state_d = S_WAIT_DONE;
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!uart_busy) begin
          if (GAP == 0) begin
            state_d = S_IDLE;
          end else begin
            gap_d   = GAP_LOAD;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == 16'd0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      byte_q    <= 8'h00;
      grant_q   <= 2'b00;
      prio1_q   <= 1'b0;
      err_q     <= 1'b0;
      tx_load_q <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      busy_q    <= 1'b0;
      gap_q     <= 16'd0;
      to_q      <= '0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      grant_q   <= grant_d;
      prio1_q   <= prio1_d;
      err_q     <= err_d;
      tx_load_q <= tx_load_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      busy_q    <= busy_d;
      gap_q     <= gap_d;
      to_q      <= to_d;
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign tx_load = tx_load_q;
  assign tx_in   = {8'h00, byte_q};
  assign busy    = busy_q;
  assign grant   = grant_q;
  assign err     = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a short-frame UartTX stub.
// Expected grants are queued by the stimulus; a negedge monitor checks every tx_load.
module tb_uart_tx_arbiter;

  localparam int GAP_T = 100;
  localparam int TO_T  = 8;
  localparam int FRAME = 30;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [7:0]  data0, data1;
  logic        ack0, ack1, tx_load;
  logic [15:0] tx_in, tx_out;
  logic        busy, err;
  logic [1:0]  grant;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.GAP(GAP_T), .BUSY_TIMEOUT(TO_T)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .tx_load(tx_load), .tx_in(tx_in), .tx_out(tx_out),
    .busy(busy), .grant(grant), .err(err)
  );

  // UartTX stub: busy from the edge after load for FRAME cycles; never reset.
  int   stub_cnt   = 0;
  logic stub_stuck = 1'b0;
  always @(posedge clk) begin
    if (tx_load && !stub_stuck) stub_cnt <= FRAME;
    else if (stub_cnt != 0)     stub_cnt <= stub_cnt - 1;
  end
  assign tx_out = (!stub_stuck && stub_cnt != 0) ? 16'h8000 : 16'h0000;

  typedef struct packed {
    logic [1:0] g;
    logic [7:0] d;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   loads    = 0;
  int   fall_cyc = -1;
  int   load_cyc = -1;
  logic prev_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (prev_busy && !tx_out[15]) fall_cyc = cyc;
    if (tx_load) begin
      loads++;
      load_cyc = cyc;
      chk("load_while_uart_idle", {31'd0, prev_busy}, 32'd0);
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_load: got tx_in=%04h expected no load", tx_in);
      end else begin
        e = expq.pop_front();
        chk("tx_in", {16'd0, tx_in}, {24'd0, e.d});
        chk("grant", {30'd0, grant}, {30'd0, e.g});
        chk("ack0", {31'd0, ack0}, {31'd0, e.g[0]});
        chk("ack1", {31'd0, ack1}, {31'd0, e.g[1]});
      end
    end else if (ack0 || ack1) begin
      chk("ack_outside_load", {30'd0, ack1, ack0}, 32'd0);
    end
    prev_busy = tx_out[15];
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_loads(input int n, input int budget, input string name);
    int b = budget;
    while (loads < n && b > 0) begin
      tick();
      b--;
    end
    chk(name, loads, n);
  endtask

  task automatic wait_idle(input int budget);
    int b = budget;
    while ((busy || tx_out[15]) && b > 0) begin
      tick();
      b--;
    end
    chk("wait_idle", {30'd0, busy, tx_out[15]}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    int t;
    reset = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    data0 = 8'h00;
    data1 = 8'h00;
    tick();
    do_reset();

    chk("rst_tx_in", {16'd0, tx_in}, 32'd0);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_flags", {26'd0, ack0, ack1, tx_load, busy, err}, 32'd0);

    // Single request: one-cycle latency to tx_load
    base  = loads;
    req0  = 1'b1;
    data0 = 8'h41;
    expq.push_back('{g: 2'b01, d: 8'h41});
    tick();
    chk("latency_tx_load", {31'd0, tx_load}, 32'd1);
    req0 = 1'b0;
    wait_idle(400);

    // Both held from reset: req0 first, then strict alternation
    do_reset();
    base  = loads;
    req0  = 1'b1;
    req1  = 1'b1;
    data0 = 8'h55;
    data1 = 8'hAA;
    expq.push_back('{g: 2'b01, d: 8'h55});
    expq.push_back('{g: 2'b10, d: 8'hAA});
    expq.push_back('{g: 2'b01, d: 8'h55});
    expq.push_back('{g: 2'b10, d: 8'hAA});
    wait_loads(base + 4, 2000, "alternation_loads");
    req0 = 1'b0;
    req1 = 1'b0;
    wait_idle(400);

    // Back-to-back req1: next load exactly GAP+2 cycles after busy falls
    base  = loads;
    req1  = 1'b1;
    data1 = 8'h10;
    expq.push_back('{g: 2'b10, d: 8'h10});
    expq.push_back('{g: 2'b10, d: 8'h11});
    wait_loads(base + 1, 100, "gap_first_load");
    data1 = 8'h11;
    wait_loads(base + 2, 400, "gap_second_load");
    req1 = 1'b0;
    chk("gap_spacing", load_cyc - fall_cyc, GAP_T + 2);
    wait_idle(400);

    // A req0 pulse while the UART is busy is withdrawn, never acked
    base  = loads;
    req1  = 1'b1;
    data1 = 8'h5A;
    expq.push_back('{g: 2'b10, d: 8'h5A});
    wait_loads(base + 1, 100, "pulse_setup_load");
    req1 = 1'b0;
    repeat (3) tick();
    req0  = 1'b1;
    data0 = 8'h77;
    tick();
    req0 = 1'b0;
    wait_idle(400);
    repeat (10) tick();
    chk("pulse_no_extra_load", loads, base + 1);
    chk("pulse_queue_empty", expq.size(), 0);

    // Reset mid-frame with req1 held: regrant only once the UART goes idle
    base  = loads;
    req1  = 1'b1;
    data1 = 8'h33;
    expq.push_back('{g: 2'b10, d: 8'h33});
    wait_loads(base + 1, 100, "midreset_first_load");
    data1 = 8'h34;
    expq.push_back('{g: 2'b10, d: 8'h34});
    repeat (5) tick();
    do_reset();
    chk("midreset_grant", {30'd0, grant}, 32'd0);
    chk("midreset_tx_in", {16'd0, tx_in}, 32'd0);
    chk("midreset_uart_busy", {31'd0, tx_out[15]}, 32'd1);
    wait_loads(base + 2, 200, "midreset_regrant");
    req1 = 1'b0;
    chk("midreset_spacing", load_cyc - fall_cyc, 1);
    wait_idle(400);

    // Stuck UART: busy never rises, err after LOAD plus TO_T wait cycles
    stub_stuck = 1'b1;
    base  = loads;
    req0  = 1'b1;
    data0 = 8'h99;
    expq.push_back('{g: 2'b01, d: 8'h99});
    wait_loads(base + 1, 50, "timeout_load");
    req0 = 1'b0;
    chk("timeout_err_low_at_load", {31'd0, err}, 32'd0);
    t = 0;
    while (!err && t < 40) begin
      tick();
      t++;
    end
    chk("timeout_cycles", t, TO_T + 1);
    chk("timeout_back_to_idle", {31'd0, busy}, 32'd0);
    repeat (5) tick();
    chk("err_sticky", {31'd0, err}, 32'd1);
    do_reset();
    chk("err_cleared_by_reset", {31'd0, err}, 32'd0);
    stub_stuck = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UartTX transmitter between two byte requesters (req0: CPU memory-mapped port, req1: debug/monitor path).
- Round-robin arbitration with req/ack handshake.
- Drives UartTX load/in and tracks completion using UartTX out[15] (busy flag, 16'h8000 while sending).
- Enforces a programmable idle gap between frames.

Parameters:
- GAP, 0, extra idle clk cycles inserted after UartTX busy falls before the next grant (0..65535).
- BUSY_TIMEOUT, 8, max cycles to wait for busy to rise after load; on expiry the arbiter flags err and returns to IDLE.

Ports:
- clk  in  1  system clock, single domain
- reset  in  1  synchronous, active-high reset
- req0  in  1  requester 0 has a byte; held high until ack0
- data0  in  8  requester 0 byte; valid while req0 high
- ack0  out  1  one-cycle pulse: data0 accepted and loaded into UartTX
- req1  in  1  requester 1 request
- data1  in  8  requester 1 byte
- ack1  out  1  one-cycle accept pulse for requester 1
- tx_load  out  1  to UartTX load; one-cycle pulse
- tx_in  out  16  to UartTX in; {8'h00, granted byte}
- tx_out  in  16  from UartTX out; bit 15 = busy
- busy  out  1  high in any state other than IDLE
- grant  out  2  one-hot owner of the current or last frame (01 = req0, 10 = req1)
- err  out  1  sticky: busy-rise timeout occurred; cleared only by reset

Behaviour:
- Reset values: ack0/ack1/tx_load/busy/err = 0, tx_in = 0, grant = 00, rr pointer favours req0, state IDLE, gap counter 0. Reset has priority over all events in the same cycle.
- UartTX has no reset. IDLE grants only when tx_out[15] = 0, so reset mid-frame never overlaps frames.
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - Arbitrate only if tx_out[15] = 0 and (req0 | req1).
  - Single request: that requester wins.
  - Both: the requester not granted last wins. After reset, req0 wins.
  - At the grant edge: capture the winner's data into tx_in[7:0], set grant, go to LOAD.
- LOAD (1 cycle):
  - tx_load = 1; the winner's ack = 1.
  - Update rr pointer to the winner.
  - Go to WAIT_BUSY.
- WAIT_BUSY:
  - tx_out[15] = 1 -> WAIT_DONE.
  - Otherwise count. After BUSY_TIMEOUT cycles: set err, go to IDLE.
- WAIT_DONE: hold until tx_out[15] = 0. Then:
  - GAP = 0 -> IDLE.
  - Otherwise load the gap counter and go to GAP.
- GAP: count down GAP cycles, then go to IDLE.
- Latency: req sampled high in IDLE with UART idle at edge N -> tx_load and ack high during cycle N+1.
- Frame duration is set by UartTX: 10 bits x 217 clk, about 2170 cycles.
- Throughput: one byte per frame + GAP + 3 cycles of overhead (LOAD, WAIT_BUSY, IDLE).
- ack is never asserted for a requester whose req was low at the grant edge. Dropping req before the grant withdraws the request.
- A requester must deassert req or present new data the cycle after ack. A req still high after ack is treated as a new byte.
- tx_in holds its value after LOAD until the next grant.
- tx_load and ack are never high outside LOAD. ack0 and ack1 are mutually exclusive.
- The GAP counter is 16 bits. The timeout counter is sized to hold BUSY_TIMEOUT; no wrap-around.

Test Plan:
- Reset, then req0 = 1, data0 = 8'h41 -> one cycle later tx_load = 1, tx_in = 16'h0041, ack0 = 1, grant = 01. UartTX TX shows start bit, 0x41 LSB-first, stop bit. busy drops about 2170 cycles later.
- req0 and req1 held continuously with data0 = 8'h55, data1 = 8'hAA -> frames alternate 55, AA, 55, AA. Each ack occurs only in its LOAD cycle; acks never overlap.
- GAP = 100 and back-to-back req1 -> the next tx_load comes exactly 100 + 2 cycles after tx_out[15] falls.
- tx_out tied to 0 (stub UART), req0 pulse -> tx_load, then err = 1 after 8 cycles, state IDLE. err stays 1 until reset.
- Reset asserted mid-frame while UartTX busy, req1 held high -> after reset no tx_load until tx_out[15] = 0, then req1 is granted with ack1.
- req0 asserted for 1 cycle while UART busy, then dropped -> no ack0 and no tx_load for that request.
